// File: rtl/ysyx_20020207_clint.sv
// CLINT timer block: 64-bit mtime behind a prescaler, readable over a minimal AXI4-lite read channel.
// Optional macro YSYX_20020207_CLINT_SNAPSHOT_EN: a read of mtime[31:0] latches mtime[63:32] for the next high-word read.
module ysyx_20020207_clint #(
  parameter int unsigned DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [15:0] PRESCALE_MAX  = 16'(DIV - 1);
  localparam logic [15:0] MTIME_LO_ADDR = 16'hbff8;
  localparam logic [15:0] MTIME_HI_ADDR = 16'hbffc;
  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] mtime;
  logic [15:0] prescaler;
  logic [15:0] addr_lo;
  logic        ar_fire;
  logic        r_fire;
  logic [31:0] rdata_nxt;
  logic [1:0]  rresp_nxt;
  logic        unused_addr_hi;

  assign addr_lo        = araddr[15:0];
  assign unused_addr_hi = ^araddr[31:16];
  assign ar_fire        = (state == IDLE) && arvalid && arready;
  assign r_fire         = (state == RESP) && rvalid && rready;

  // The timebase runs regardless of bus activity or backpressure.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= 16'h0;
      mtime     <= 64'h0;
    end else if (prescaler == PRESCALE_MAX) begin
      prescaler <= 16'h0;
      mtime     <= mtime + 64'h1;
    end else begin
      prescaler <= prescaler + 16'h1;
    end
  end

`ifdef YSYX_20020207_CLINT_SNAPSHOT_EN
  logic [31:0] mtime_hi_shadow;

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_hi_shadow <= 32'h0;
    end else if (ar_fire && (addr_lo == MTIME_LO_ADDR)) begin
      mtime_hi_shadow <= mtime[63:32];
    end
  end
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    rdata_nxt = 32'h0;
    rresp_nxt = RESP_SLVERR;
    if (addr_lo == MTIME_LO_ADDR) begin
      rdata_nxt = mtime[31:0];
      rresp_nxt = RESP_OKAY;
    end else if (addr_lo == MTIME_HI_ADDR) begin
`ifdef YSYX_20020207_CLINT_SNAPSHOT_EN
      rdata_nxt = mtime_hi_shadow;
`else
      rdata_nxt = mtime[63:32];
`endif
      rresp_nxt = RESP_OKAY;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ar_fire) state_nxt = RESP;
      RESP: if (r_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so arready returns
  // one cycle after the R handshake and one cycle after reset releases.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
      rresp   <= RESP_OKAY;
    end else begin
      state   <= state_nxt;
      arready <= (state_nxt == IDLE);
      rvalid  <= (state_nxt == RESP);
      if (ar_fire) begin
        rdata <= rdata_nxt;
        rresp <= rresp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_clint.sv
// Self-checking bench for ysyx_20020207_clint: two instances (DIV=1, DIV=4) share one read master.
// Expected mtime is derived from the number of post-reset clock edges, not from the design's counters.
module tb_ysyx_20020207_clint;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = 32'h0;
  logic        rready = 1'b0;

  logic        arready1, rvalid1, arready4, rvalid4;
  logic [31:0] rdata1, rdata4;
  logic [1:0]  rresp1, rresp4;

  int total = 0;
  int bad   = 0;

  logic [63:0] cnt = 64'h0;     // rising edges seen with reset low since the last reset
  logic [63:0] off1 = 64'h0;    // correction applied to the DIV=1 model after a forced mtime
  logic [31:0] shadow1 = 32'h0;
  logic [31:0] shadow4 = 32'h0;

  ysyx_20020207_clint #(.DIV(1)) dut1 (
    .clock(clock), .reset(reset), .arvalid(arvalid), .araddr(araddr), .arready(arready1),
    .rvalid(rvalid1), .rready(rready), .rdata(rdata1), .rresp(rresp1)
  );

  ysyx_20020207_clint #(.DIV(4)) dut4 (
    .clock(clock), .reset(reset), .arvalid(arvalid), .araddr(araddr), .arready(arready4),
    .rvalid(rvalid4), .rready(rready), .rdata(rdata4), .rresp(rresp4)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) cnt <= 64'h0;
    else       cnt <= cnt + 64'h1;
  end

  function automatic logic [63:0] mt1();
    return cnt + off1;
  endfunction

  function automatic logic [63:0] mt4();
    return cnt / 64'd4;
  endfunction

  function automatic logic [33:0] expect_resp(input logic [15:0] a, input logic [63:0] t,
                                              input logic [31:0] shadow);
    if (a == 16'hbff8) return {2'b00, t[31:0]};
`ifdef YSYX_20020207_CLINT_SNAPSHOT_EN
    if (a == 16'hbffc) return {2'b00, shadow};
`else
    if (a == 16'hbffc) return {2'b00, t[63:32]};
`endif
    return {2'b10, 32'h0};
  endfunction

  // One read transaction on both instances; called at a falling edge, returns at a falling edge
  // in the cycle after the R handshake.
  task automatic do_read(input logic [31:0] addr, input int stall, input string tag);
    int w;
    logic [33:0] e1, e4;
    logic [35:0] x1, x4;
    w = 0;
    while (!(arready1 && arready4) && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (w == 20) begin
      total++; bad++;
      $display("FAIL %s ar_wait: arready never rose (got %b/%b, need 1/1)", tag, arready1, arready4);
      return;
    end
    arvalid = 1'b1;
    araddr  = addr;
    rready  = (stall == 0);
    e1 = expect_resp(addr[15:0], mt1(), shadow1);
    e4 = expect_resp(addr[15:0], mt4(), shadow4);
    if (addr[15:0] == 16'hbff8) begin
      shadow1 = mt1() >> 32;
      shadow4 = mt4() >> 32;
    end
    x1 = {1'b1, 1'b0, e1};
    x4 = {1'b1, 1'b0, e4};
    @(negedge clock);
    arvalid = 1'b0;
    araddr  = $urandom;
    total++;
    if ({rvalid1, arready1, rresp1, rdata1} !== x1) begin
      bad++;
      $display("FAIL %s resp_div1: got v=%b r=%b resp=%b data=%h, need v=%b r=%b resp=%b data=%h",
               tag, rvalid1, arready1, rresp1, rdata1, x1[35], x1[34], x1[33:32], x1[31:0]);
    end
    total++;
    if ({rvalid4, arready4, rresp4, rdata4} !== x4) begin
      bad++;
      $display("FAIL %s resp_div4: got v=%b r=%b resp=%b data=%h, need v=%b r=%b resp=%b data=%h",
               tag, rvalid4, arready4, rresp4, rdata4, x4[35], x4[34], x4[33:32], x4[31:0]);
    end
    for (int i = 0; i < stall; i++) begin
      arvalid = 1'($urandom);
      araddr  = $urandom;
      @(negedge clock);
      total++;
      if ({rvalid1, arready1, rresp1, rdata1, rvalid4, arready4, rresp4, rdata4} !== {x1, x4}) begin
        bad++;
        $display("FAIL %s stall%0d: got %b%b %h / %b%b %h, need %b%b %h / %b%b %h", tag, i,
                 rvalid1, arready1, rdata1, rvalid4, arready4, rdata4,
                 x1[35], x1[34], x1[31:0], x4[35], x4[34], x4[31:0]);
      end
    end
    // Keep arvalid high in the R-handshake cycle; it must not be accepted.
    rready  = 1'b1;
    arvalid = 1'b1;
    araddr  = 32'h2000bff8;
    @(negedge clock);
    arvalid = 1'b0;
    rready  = 1'b0;
    total++;
    if ({rvalid1, arready1, rvalid4, arready4} !== 4'b0101) begin
      bad++;
      $display("FAIL %s after_r: got v/r=%b%b %b%b, need 01 01", tag, rvalid1, arready1, rvalid4, arready4);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic release_reset();
    reset   = 1'b0;
    off1    = 64'h0;
    shadow1 = 32'h0;
    shadow4 = 32'h0;
    arvalid = 1'b0;
    rready  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(3);
    total++;
    if ({arready1, rvalid1, rresp1, rdata1, arready4, rvalid4, rresp4, rdata4} !== 70'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %b%b %b %h / %b%b %b %h, need all zero",
               arready1, rvalid1, rresp1, rdata1, arready4, rvalid4, rresp4, rdata4);
    end
    release_reset();
    total++;
    if ({dut1.mtime, dut4.mtime, dut4.prescaler, arready1} !== {128'h0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL first_cycle: got mtime=%h/%h presc=%0d arready=%b, need 0/0 0 0",
               dut1.mtime, dut4.mtime, dut4.prescaler, arready1);
    end
    @(negedge clock);
    total++;
    if ({arready1, arready4, dut1.mtime} !== {2'b11, mt1()}) begin
      bad++;
      $display("FAIL arready_rise: got %b%b mtime=%h, need 11 mtime=%h", arready1, arready4, dut1.mtime, mt1());
    end
  endtask

  task automatic test_first_read();
    while (cnt < 64'd9) @(negedge clock);
    do_read(32'h2000bff8, 0, "mtime9");
  endtask

  task automatic test_div4();
    while (cnt < 64'd40) @(negedge clock);
    do_read(32'h2000bff8, 0, "div4_40");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++;
      if ({dut4.prescaler, dut4.mtime} !== {16'(cnt % 64'd4), mt4()}) begin
        bad++;
        $display("FAIL prescaler%0d: got presc=%0d mtime=%0d, need presc=%0d mtime=%0d",
                 i, dut4.prescaler, dut4.mtime, cnt % 64'd4, mt4());
      end
    end
  endtask

  task automatic test_backpressure();
    do_read(32'h2000bff8, 5, "stall5");
  endtask

  task automatic test_slverr();
    do_read(32'h2000bff0, 0, "slverr");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) do_read(i[0] ? 32'h0200bffc : 32'h0200bff8, 0, "b2b");
  endtask

  task automatic test_random();
    logic [15:0] lo;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: lo = 16'hbff8;
        1: lo = 16'hbffc;
        default: begin
          lo = 16'($urandom);
          if (lo == 16'hbff8 || lo == 16'hbffc) lo = 16'h0004;
        end
      endcase
      do_read({16'($urandom), lo}, $urandom_range(0, 3), "random");
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  task automatic test_wrap_snapshot();
    @(negedge clock);
    force dut1.mtime = 64'h0000_0000_FFFF_FFFF;
    @(negedge clock);
    release dut1.mtime;
    off1 = 64'h0000_0000_FFFF_FFFF - cnt;
    do_read(32'h2000bff8, 0, "wrap_lo");
    repeat (2) @(negedge clock);
    do_read(32'h2000bffc, 0, "wrap_hi");
  endtask

  task automatic test_reset_in_resp();
    int w;
    w = 0;
    while (!arready1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    arvalid = 1'b1;
    araddr  = 32'h2000bff8;
    rready  = 1'b0;
    @(negedge clock);
    arvalid = 1'b0;
    total++;
    if ({rvalid1, rvalid4} !== 2'b11) begin
      bad++;
      $display("FAIL abort_pre: got rvalid=%b%b, need 11", rvalid1, rvalid4);
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({rvalid1, arready1, rvalid4, arready4, dut1.mtime, dut4.mtime} !== 132'h0) begin
      bad++;
      $display("FAIL abort_reset: got v/r=%b%b %b%b mtime=%h/%h, need 00 00 0/0",
               rvalid1, arready1, rvalid4, arready4, dut1.mtime, dut4.mtime);
    end
    release_reset();
    rready = 1'b1;
    @(negedge clock);
    total++;
    if ({rvalid1, arready1, rvalid4, arready4} !== 4'b0101) begin
      bad++;
      $display("FAIL abort_release: got v/r=%b%b %b%b, need 01 01", rvalid1, arready1, rvalid4, arready4);
    end
    rready = 1'b0;
    do_read(32'h2000bff8, 1, "post_abort");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, need finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_read();
    test_div4();
    test_backpressure();
    test_slverr();
    test_back_to_back();
    test_random();
    test_wrap_snapshot();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_20020207_clint.md
YSYX_20020207_CLINT -- requirements
Module: ysyx_20020207_clint

Interface
REQ-001 SHALL have parameter DIV, default 1, meaning core-clock cycles per mtime increment; legal range 1..65535.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port arvalid  input  1  AXI4-lite read-address valid from the crossbar.
REQ-005 SHALL have port araddr  input  32  read address; only araddr[15:0] decoded.
REQ-006 SHALL have port arready  output  1  read-address ready.
REQ-007 SHALL have port rvalid  output  1  read-data valid.
REQ-008 SHALL have port rready  input  1  read-data ready from the crossbar.
REQ-009 SHALL have port rdata  output  32  read data.
REQ-010 SHALL have port rresp  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR.

Function
REQ-011 SHALL hold a 64-bit free-running counter mtime and a 16-bit prescaler.
REQ-012 SHALL increment the prescaler every cycle; on prescaler==DIV-1, prescaler wraps to 0 and mtime increments by 1 the same edge; DIV=1 increments mtime every cycle.
REQ-013 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 without any flag or stall.
REQ-014 SHALL implement a two-state FSM: IDLE (arready=1, rvalid=0) and RESP (arready=0, rvalid=1); arready and rvalid are registered.
REQ-015 SHALL transition IDLE->RESP on the edge where arvalid&&arready; rvalid rises exactly one cycle after the AR handshake cycle.
REQ-016 SHALL capture rdata/rresp at the AR-handshake edge from the mtime value present in that handshake cycle (pre-increment).
REQ-017 SHALL decode araddr[15:0]==16'hbff8 as mtime[31:0] and 16'hbffc as mtime[63:32], rresp=2'b00.
REQ-018 SHALL return rdata=32'h0, rresp=2'b10 for any other araddr[15:0]; FSM timing identical to legal reads.
REQ-019 SHALL hold rvalid, rdata, rresp stable in RESP until rvalid&&rready; on that edge go to IDLE, arready=1 next cycle.
REQ-020 SHALL accept no new address in the cycle of the R handshake; maximum throughput one read per two cycles.
REQ-021 SHALL ignore araddr changes and arvalid while in RESP.
REQ-022 SHALL keep counting mtime independent of FSM state and backpressure.

Reset
REQ-023 SHALL on reset set mtime=0, prescaler=0, FSM=IDLE, arready=0, rvalid=0, rdata=0, rresp=2'b00.
REQ-024 SHALL assert arready in the first cycle after reset deasserts.
REQ-025 SHALL abort an in-flight read when reset asserts in RESP: rvalid=0 next cycle, no response replayed.
REQ-026 SHALL count the first post-reset cycle as prescaler=0, mtime=0.

Configuration
REQ-027 SHALL support macro YSYX_20020207_CLINT_SNAPSHOT_EN.
REQ-028 With the macro defined, an OKAY read of 0xbff8 SHALL latch mtime[63:32] of the same handshake cycle into a 32-bit shadow, and 0xbffc SHALL return the shadow (reset value 0), giving tear-free low-then-high reads.
REQ-029 Without the macro, 0xbffc SHALL return live mtime[63:32] at the handshake cycle and no shadow register is built.

Verification
REQ-030 DIV=1, reset released, AR 0x2000bff8 issued in 10th post-reset cycle (mtime=9), rready=1 -> rvalid next cycle, rdata=32'h9, rresp=00.
REQ-031 DIV=4, read 0xbff8 after 40 post-reset cycles -> rdata=32'd10; prescaler sequence 0,1,2,3,0 observed.
REQ-032 rready held 0 for 5 cycles in RESP -> rvalid, rdata constant throughout, arready=0; arready=1 the cycle after rready=1 handshake.
REQ-033 AR 0x2000bff0 -> rresp=2'b10, rdata=0, one-cycle latency as legal read.
REQ-034 mtime forced to 64'h0000_0000_FFFF_FFFF, read 0xbff8 then 0xbffc four cycles later -> SNAPSHOT_EN: 32'hFFFF_FFFF, 32'h0; without: 32'hFFFF_FFFF, 32'h1.
REQ-035 reset asserted while rvalid=1 -> next cycle rvalid=0, arready=0, mtime=0; arready=1 the cycle after reset deasserts.
